// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU control-bus sequencer: field widths, bus
// constants, phase encoding and the request payload carried through the FIFO.
package alu_bus_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ACT_W  = 4;

    localparam logic [ADDR_W-1:0] ADDR_ALU_B  = 5'b11000;
    localparam logic [1:0]        ADDR_ROM_HI = 2'b10;

    localparam logic [ACT_W-1:0] ACT_NONE = 4'd0;
    localparam logic [ACT_W-1:0] ACT_CPL  = 4'd1;
    localparam logic [ACT_W-1:0] ACT_CLL  = 4'd2;
    localparam logic [ACT_W-1:0] ACT_SRU  = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_P3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] raddr;
        logic [ADDR_W-1:0] waddr;
        logic [ACT_W-1:0]  action;
    } req_t;

    // ALU ROM window decode on the read address.
    function automatic logic is_rom_addr(input logic [ADDR_W-1:0] a);
        return a[4:3] == ADDR_ROM_HI;
    endfunction

endpackage

// File: rtl/alu_bus_sequencer_if.sv
// Request handshake plus ALU bus fields; master is the sequencer, slave is the
// control unit / decoder side.
interface alu_bus_sequencer_if;
    import alu_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_raddr;
    logic [ADDR_W-1:0] req_waddr;
    logic [ACT_W-1:0]  req_action;
    logic              nwaitstate;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [ACT_W-1:0]  action;
    logic              t34;
    logic              busy;
    logic              done;

    modport master (
        input  req_valid, req_raddr, req_waddr, req_action, nwaitstate,
        output req_ready, raddr, waddr, action, t34, busy, done
    );

    modport slave (
        output req_valid, req_raddr, req_waddr, req_action, nwaitstate,
        input  req_ready, raddr, waddr, action, t34, busy, done
    );

endinterface

// File: rtl/alu_bus_fifo.sv
// Synchronous request FIFO; a push is refused whenever full, even if a pop
// happens on the same edge.
module alu_bus_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 14,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_data_c,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && !r_empty;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_count  = r_count;

endmodule

// File: rtl/alu_bus_sequencer.sv
// ALU control-bus initiator: buffers requests and replays each as a 4-phase
// cycle with raddr/waddr/action stable around the active-low t34 window.
module alu_bus_sequencer
    import alu_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              nreset,
    alu_bus_sequencer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [ACT_W-1:0]  r_action;
    logic              r_t34;
    logic              r_busy;
    logic              r_done;
    logic              r_req_ready;

    req_t              w_push_data;
    req_t              w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_idle_nxt;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_push_data = '{raddr: bus.req_raddr, waddr: bus.req_waddr, action: bus.req_action};
    assign w_push      = bus.req_valid && !w_full;
    // A new transfer may only be launched from IDLE or the hold phase.
    assign w_pop       = ((r_state == ST_IDLE) || (r_state == ST_P3)) && !w_empty;
    assign w_idle_nxt  = ((r_state == ST_IDLE) || (r_state == ST_P3)) && w_empty;
    assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    alu_bus_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .i_pop    (w_pop),
        .o_data_c (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    // Fields only move on IDLE/P3 -> P0 and P3 -> IDLE, where t34 stays high.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_action    <= '0;
            r_t34       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_raddr  <= w_head.raddr;
                        r_waddr  <= w_head.waddr;
                        r_action <= w_head.action;
                        r_state  <= ST_P0;
                    end
                end
                ST_P0: begin
                    r_t34   <= 1'b0;
                    r_state <= ST_P1;
                end
                ST_P1: begin
                    r_state <= ST_P2;
                end
                ST_P2: begin
                    if (bus.nwaitstate) begin
                        r_t34   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_P3;
                    end
                end
                ST_P3: begin
                    if (w_pop) begin
                        r_raddr  <= w_head.raddr;
                        r_waddr  <= w_head.waddr;
                        r_action <= w_head.action;
                        r_state  <= ST_P0;
                    end else begin
                        r_raddr  <= '0;
                        r_waddr  <= '0;
                        r_action <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_t34   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
            r_busy      <= !w_idle_nxt || (w_count_nxt != '0);
            r_req_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.raddr     = r_raddr;
    assign bus.waddr     = r_waddr;
    assign bus.action    = r_action;
    assign bus.t34       = r_t34;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.req_ready = r_req_ready;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Directed and randomized bench for alu_bus_sequencer against a transaction-level
// model of the request queue and the 4-phase bus cycle.
module tb_alu_bus_sequencer;
    import alu_bus_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    alu_bus_sequencer_if bus_if ();

    alu_bus_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_if.master)
    );

    // Decoder view: ALU B read strobe is only active inside the t34 window.
    logic nread_alu_b;
    assign nread_alu_b = !((bus_if.t34 == 1'b0) && (bus_if.raddr == ADDR_ALU_B));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pending queue, transfer in progress and its phase
    // index (-1 when no transfer is on the bus).
    req_t m_q[$];
    req_t m_cur;
    int   m_ph = -1;
    bit   m_acc;
    bit   m_refused_on_pop;

    int   cyc = 0;
    int   c_low, c_done, c_nread_low, c_notready;
    int   done_cyc[$];
    logic       prev_t34;
    logic [13:0] prev_fields;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input logic v, input req_t d, input logic nw);
        bit can_pop = ((m_ph < 0) || (m_ph == 3)) && (m_q.size() > 0);
        bit full    = (m_q.size() >= DEPTH);
        m_acc            = v && !full;
        m_refused_on_pop = v && full && can_pop;
        if (m_ph == 2)                    m_ph = nw ? 3 : 2;
        else if (m_ph == 0 || m_ph == 1)  m_ph = m_ph + 1;
        else if (can_pop) begin
            m_cur = m_q.pop_front();
            m_ph  = 0;
        end else                          m_ph = -1;
        if (m_acc) m_q.push_back(d);
    endfunction

    task automatic check_outputs();
        req_t        ef;
        logic [13:0] now_fields;
        logic        fchg;
        ef = (m_ph >= 0) ? m_cur : '0;
        chk("t34",       32'(bus_if.t34),       32'((m_ph == 1 || m_ph == 2) ? 0 : 1));
        chk("done",      32'(bus_if.done),      32'(m_ph == 3));
        chk("raddr",     32'(bus_if.raddr),     32'(ef.raddr));
        chk("waddr",     32'(bus_if.waddr),     32'(ef.waddr));
        chk("action",    32'(bus_if.action),    32'(ef.action));
        chk("busy",      32'(bus_if.busy),      32'((m_ph >= 0) || (m_q.size() > 0)));
        chk("req_ready", 32'(bus_if.req_ready), 32'(m_q.size() < DEPTH));
        now_fields = {bus_if.raddr, bus_if.waddr, bus_if.action};
        fchg = (now_fields !== prev_fields);
        chk("inv_same_edge",  32'(fchg && (bus_if.t34 !== prev_t34)), 32'(0));
        chk("inv_fields_t34", 32'(fchg && !(prev_t34 && bus_if.t34)), 32'(0));
        prev_fields = now_fields;
        prev_t34    = bus_if.t34;
        if (bus_if.t34 == 1'b0)       c_low++;
        if (bus_if.done == 1'b1) begin
            c_done++;
            done_cyc.push_back(cyc);
        end
        if (nread_alu_b == 1'b0)      c_nread_low++;
        if (bus_if.req_ready == 1'b0) c_notready++;
    endtask

    task automatic step(input logic v, input req_t d, input logic nw);
        bus_if.req_valid  = v;
        bus_if.req_raddr  = d.raddr;
        bus_if.req_waddr  = d.waddr;
        bus_if.req_action = d.action;
        bus_if.nwaitstate = nw;
        @(posedge clk);
        cyc++;
        model_edge(v, d, nw);
        #1;
        check_outputs();
    endtask

    task automatic clear_counts();
        c_low = 0; c_done = 0; c_nread_low = 0; c_notready = 0;
        done_cyc.delete();
    endtask

    task automatic run_until_ph(input int ph, input logic nw);
        int n = 0;
        while (m_ph != ph && n < 20) begin
            step(1'b0, '0, nw);
            n++;
        end
        chk("reach_phase", 32'(m_ph), 32'(ph));
    endtask

    task automatic drain();
        int n = 0;
        while ((m_ph >= 0 || m_q.size() > 0) && n < 200) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_idle", 32'(bus_if.busy), 32'(0));
    endtask

    task automatic push_until_accepted(input req_t d, input string tag);
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 30) begin
            step(1'b1, d, 1'b1);
            ok = m_acc;
            n++;
        end
        chk(tag, 32'(ok), 32'(1));
    endtask

    initial begin
        req_t a, b, c, d;
        bit   prev_refused;

        nreset            = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_raddr  = '0;
        bus_if.req_waddr  = '0;
        bus_if.req_action = '0;
        bus_if.nwaitstate = 1'b1;
        clear_counts();

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_raddr",  32'(bus_if.raddr),     32'(0));
        chk("rst_waddr",  32'(bus_if.waddr),     32'(0));
        chk("rst_action", 32'(bus_if.action),    32'(0));
        chk("rst_t34",    32'(bus_if.t34),       32'(1));
        chk("rst_busy",   32'(bus_if.busy),      32'(0));
        chk("rst_done",   32'(bus_if.done),      32'(0));
        chk("rst_ready",  32'(bus_if.req_ready), 32'(1));
        @(negedge clk);
        nreset      = 1'b1;
        prev_t34    = 1'b1;
        prev_fields = '0;
        step(1'b0, '0, 1'b1);

        // Asynchronous reset while a transfer sits in P1.
        a = '{raddr: ADDR_ALU_B, waddr: 5'd3, action: ACT_CPL};
        step(1'b1, a, 1'b1);
        run_until_ph(1, 1'b1);
        chk("mid_p1_t34_low", 32'(bus_if.t34), 32'(0));
        bus_if.req_valid = 1'b0;
        #2 nreset = 1'b0;
        #1;
        chk("arst_t34",    32'(bus_if.t34),    32'(1));
        chk("arst_raddr",  32'(bus_if.raddr),  32'(0));
        chk("arst_waddr",  32'(bus_if.waddr),  32'(0));
        chk("arst_action", 32'(bus_if.action), 32'(0));
        chk("arst_done",   32'(bus_if.done),   32'(0));
        chk("arst_busy",   32'(bus_if.busy),   32'(0));
        m_q.delete();
        m_ph = -1;
        repeat (2) @(posedge clk);
        #3 nreset = 1'b1;
        prev_t34    = bus_if.t34;
        prev_fields = {bus_if.raddr, bus_if.waddr, bus_if.action};
        clear_counts();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("arst_no_done",   32'(c_done),           32'(0));
        chk("arst_ready_rel", 32'(bus_if.req_ready), 32'(1));

        // Single transfer to ALU B.
        clear_counts();
        a = '{raddr: ADDR_ALU_B, waddr: 5'd0, action: ACT_NONE};
        step(1'b1, a, 1'b1);
        chk("single_pushed_not_popped", 32'(bus_if.raddr), 32'(0));
        step(1'b0, '0, 1'b1);
        chk("single_raddr_k1", 32'(bus_if.raddr), 32'(ADDR_ALU_B));
        drain();
        chk("single_t34_low_clocks", 32'(c_low),       32'(2));
        chk("single_done_pulses",    32'(c_done),      32'(1));
        chk("single_nread_low",      32'(c_nread_low), 32'(2));
        chk("single_raddr_idle",     32'(bus_if.raddr), 32'(0));

        // Three back-to-back requests into a two-entry FIFO.
        clear_counts();
        a = '{raddr: 5'd1,  waddr: ADDR_ALU_B, action: ACT_NONE};
        b = '{raddr: 5'd2,  waddr: 5'd4,       action: ACT_CPL};
        c = '{raddr: 5'd17, waddr: 5'd9,       action: ACT_SRU};
        push_until_accepted(a, "b2b_push0");
        push_until_accepted(b, "b2b_push1");
        push_until_accepted(c, "b2b_push2");
        drain();
        chk("b2b_ready_dropped", 32'(c_notready > 0), 32'(1));
        chk("b2b_done_pulses",   32'(c_done),         32'(3));
        if (done_cyc.size() == 3) begin
            chk("b2b_gap0", 32'(done_cyc[1] - done_cyc[0]), 32'(4));
            chk("b2b_gap1", 32'(done_cyc[2] - done_cyc[1]), 32'(4));
        end

        // Wait states stretch the strobe window.
        clear_counts();
        a = '{raddr: 5'd5, waddr: 5'd6, action: ACT_CLL};
        step(1'b1, a, 1'b1);
        run_until_ph(1, 1'b1);
        repeat (5) step(1'b0, '0, 1'b0);
        chk("wait_no_done_yet", 32'(c_done), 32'(0));
        step(1'b0, '0, 1'b1);
        chk("wait_done_after_release", 32'(bus_if.done),   32'(1));
        chk("wait_action_held",        32'(bus_if.action), 32'(ACT_CLL));
        drain();
        chk("wait_t34_low_clocks", 32'(c_low),  32'(6));
        chk("wait_done_pulses",    32'(c_done), 32'(1));

        // Push offered while full on the same edge as a P3 pop.
        clear_counts();
        a = '{raddr: 5'd8,  waddr: 5'd1, action: ACT_CPL};
        b = '{raddr: 5'd9,  waddr: 5'd2, action: ACT_CLL};
        c = '{raddr: 5'd10, waddr: 5'd3, action: ACT_SRU};
        d = '{raddr: 5'd20, waddr: 5'd4, action: ACT_CPL};
        push_until_accepted(a, "full_push_a");
        push_until_accepted(b, "full_push_b");
        push_until_accepted(c, "full_push_c");
        begin
            int  n = 0;
            bit  ok = 1'b0;
            bit  seen = 1'b0;
            prev_refused = 1'b0;
            while (!ok && n < 30) begin
                step(1'b1, d, 1'b1);
                if (prev_refused) chk("accept_after_pop", 32'(m_acc), 32'(1));
                if (m_refused_on_pop) seen = 1'b1;
                prev_refused = m_refused_on_pop;
                ok = m_acc;
                n++;
            end
            chk("full_push_d",       32'(ok),   32'(1));
            chk("refused_on_p3_pop", 32'(seen), 32'(1));
        end
        drain();
        chk("full_done_pulses", 32'(c_done), 32'(4));

        // Randomized traffic with occasional wait states.
        for (int i = 0; i < 400; i++) begin
            req_t r;
            r.raddr  = ADDR_W'($urandom);
            r.waddr  = ADDR_W'($urandom);
            r.action = ACT_W'($urandom);
            step(($urandom % 3) != 0, r, ($urandom % 4) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bus_sequencer.md
Name: alu_bus_sequencer

Overview:
- Initiator side of the ALU control-bus interface. Drives the fields that the ALU address decoder consumes: raddr, waddr, action and the t34 strobe window.
- Accepts transfer requests from microcode/test logic over a valid/ready handshake and buffers them in a small FIFO.
- Replays each transfer as a 4-phase processor cycle with fields stable before, during and after the t34 window.
- Sits between the control unit and the ALU decoder/ALU board.

Parameters:
- FIFO_DEPTH, 2, request buffer entries (power of two, >=2)
- ADDR_W, 5, width of raddr/waddr fields
- ACT_W, 4, width of action field

Ports:
- clk  in  1  system clock, one tick per phase
- nreset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= !full, registered)
- req_raddr  in  ADDR_W  read address for transfer
- req_waddr  in  ADDR_W  write address for transfer
- req_action  in  ACT_W  action code for transfer
- nwaitstate  in  1  active-low; extends the t34 window while low
- raddr  out  ADDR_W  bus read address
- waddr  out  ADDR_W  bus write address
- action  out  ACT_W  bus action code
- t34  out  1  active-low strobe window (decoder strobes assert when 0)
- busy  out  1  high in any non-IDLE state or when FIFO non-empty
- done  out  1  one-clock pulse when a transfer's t34 window closes

Behaviour:
- Reset (async, nreset=0):
  - raddr=0, waddr=0, action=0, t34=1, busy=0, done=0, req_ready=1.
  - FIFO flushed; state=IDLE.
  - Reset mid-cycle: t34 returns to 1 immediately, without waiting for a clock edge; the in-flight transfer is dropped and no done pulse is issued.
- Handshake: a push occurs on a rising edge with req_valid && req_ready. req_ready reflects full only. When full, a push is refused even if a pop happens on the same edge.
- FSM states: IDLE, P0 (setup), P1 (strobe), P2 (strobe/wait), P3 (hold). One clock per phase, except P2, which may stretch.
- IDLE:
  - Fields are 0; t34=1.
  - If the FIFO is non-empty: pop the head, load raddr/waddr/action, go to P0.
- P0: t34=1, fields stable. Next state is P1.
- P1: t34=0. Next state is P2.
- P2: t34=0.
  - If nwaitstate=0, stay in P2; t34 is held low and fields are held.
  - If nwaitstate=1, go to P3.
- P3:
  - t34=1 and fields held (hold time after the strobe); done=1 for this single clock.
  - If the FIFO is non-empty: pop, load the new fields, go to P0 (back-to-back, 4 clocks per transfer).
  - If the FIFO is empty: fields go to 0, go to IDLE.
- Invariant: fields change only on edges where t34 is 1 both before and after. t34 and the fields never change on the same edge.
- Latency:
  - Request pushed at edge k into an empty, idle FIFO: pop at k+1 (fields visible, P0).
  - t34 low for edges k+2..k+4; done in P3 at k+4.
- Simultaneous push and pop on an empty FIFO: the push lands and is popped on the following edge. No bypass.
- FIFO pointers wrap modulo FIFO_DEPTH. A count register one bit wider than the pointers distinguishes full from empty.

Decomposition:
- Shared package alu_bus_pkg:
  - Phase/state encoding.
  - ALU bus addresses: ADDR_ALU_B=5'b11000; ALU ROM range raddr[4:3]=2'b10.
  - Action codes: ACT_NONE=0, ACT_CPL=1, ACT_CLL=2, ACT_SRU=7.
- One sub-module, alu_bus_fifo: a parameterised synchronous FIFO (push/pop/full/empty, async active-low reset) carrying {raddr, waddr, action}.

Test Plan:
- Reset mid-P1 with a request in flight -> t34=1 and fields 0 within 1 ns of nreset falling; FIFO empty; no done pulse; after release, req_ready=1.
- Single push {raddr=11000, waddr=0, action=0} -> raddr=11000 from k+1, t34 low exactly 2 clocks, one done pulse, return to IDLE with raddr=0; decoder model shows nread_alu_b low only while t34=0.
- Three back-to-back pushes (waddr=11000, action=0001, action=0111) with FIFO_DEPTH=2 -> req_ready drops after the 2nd unpopped entry; transfers execute in order at 4 clocks each; exactly 3 done pulses.
- nwaitstate held low 5 clocks during P2 with action=0010 -> t34 low 6 clocks, action stable throughout; done pulse one clock after release.
- Push offered while full on the same edge as a P3 pop -> push refused; entry accepted next edge; no loss or duplication.
- Every edge of the run -> checker confirms t34 and the fields never change on the same edge, and fields never change while t34=0.
